// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ/PIPE datapath: instruction codes, status codes,
// special register IDs and the write-back FSM states.
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  localparam logic [3:0] RSP_IDX = 4'd4;
  localparam logic [3:0] RNONE   = 4'd15;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } wb_state_t;

endpackage

// File: rtl/y86_dst_sel.sv
// Destination register selection for Y86-64 write-back: derives dstE/dstM from
// icode, rA, rB and the cmov condition. Purely combinational.
module y86_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  // rrmovq doubles as cmovXX, so a failed condition suppresses its E write.
  always_comb begin
    dst_e = RNONE;
    case (icode)
      IRRMOVQ:                     dst_e = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:               dst_e = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RSP_IDX;
      default:                     dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    case (icode)
      IMRMOVQ, IPOPQ: dst_m = rA;
      default:        dst_m = RNONE;
    endcase
  end

endmodule

// File: rtl/seq_writeback.sv
// SEQ register file and write-back stage: 15 program registers with two combinational
// decode read ports, end-of-instruction commit of valE/valM, and RUN/HALT status tracking.
module seq_writeback
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [2:0]        stat_in,
  input  logic [3:0]        rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [3:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [2:0]        stat_out,
  output logic              halted,
  output logic [31:0]       commit_cnt
);

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  wb_state_t         state;
  wb_state_t         next_state;
  logic              reg_we;
  logic              cnt_en;
  logic [2:0]        stat_next;
  logic              we_e;
  logic              we_m;

  y86_dst_sel u_dst_sel (
    .icode (icode),
    .rA    (rA),
    .rB    (rB),
    .cnd   (cnd),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Any commit while running counts, including the one that halts the machine.
  always_comb begin
    next_state = state;
    reg_we     = 1'b0;
    cnt_en     = 1'b0;
    stat_next  = stat_out;
    case (state)
      ST_RUN: begin
        if (commit) begin
          cnt_en = 1'b1;
          if (icode == IHALT || stat_in != SAOK) begin
            next_state = ST_HALT;
            stat_next  = (icode == IHALT) ? SHLT : stat_in;
          end else begin
            reg_we = 1'b1;
          end
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase
  end

  assign halted = (state == ST_HALT);
  assign we_m   = reg_we && (dst_m != RNONE);
  assign we_e   = reg_we && (dst_e != RNONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_out   <= SAOK;
      commit_cnt <= '0;
    end else begin
      stat_out <= stat_next;
      if (cnt_en) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
    end
  end

  // The M port is checked first so popq %rsp keeps the popped value, not the stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && dst_m == 4'(i)) begin
          regs[i] <= valM;
        end else if (we_e && dst_e == 4'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

  always_comb begin
    rd_a_data = '0;
    if (rd_a_addr != RNONE) begin
      rd_a_data = regs[rd_a_addr];
    end
  end

  always_comb begin
    rd_b_data = '0;
    if (rd_b_addr != RNONE) begin
      rd_b_data = regs[rd_b_addr];
    end
  end

endmodule

// File: tb/tb_seq_writeback.sv
// Self-checking bench for seq_writeback: directed Y86 scenarios followed by random
// commits, compared against a register-array reference model of the write-back rules.
module tb_seq_writeback;

  logic        clk;
  logic        rst_n;
  logic        commit;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [2:0]  stat_in;
  logic [3:0]  rd_a_addr;
  logic [63:0] rd_a_data;
  logic [3:0]  rd_b_addr;
  logic [63:0] rd_b_data;
  logic [2:0]  stat_out;
  logic        halted;
  logic [31:0] commit_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_regs [16];
  logic [2:0]  m_stat;
  logic        m_halted;
  logic [31:0] m_cnt;

  seq_writeback #(.DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (commit),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .cnd        (cnd),
    .valE       (valE),
    .valM       (valM),
    .stat_in    (stat_in),
    .rd_a_addr  (rd_a_addr),
    .rd_a_data  (rd_a_data),
    .rd_b_addr  (rd_b_addr),
    .rd_b_data  (rd_b_data),
    .stat_out   (stat_out),
    .halted     (halted),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] modelDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
    if (ic == 4'd2) return c ? b : 4'd15;
    if (ic inside {4'd3, 4'd6}) return b;
    if (ic inside {[4'd8:4'd11]}) return 4'd4;
    return 4'd15;
  endfunction

  function automatic logic [3:0] modelDstM(input logic [3:0] ic, input logic [3:0] a);
    return (ic inside {4'd5, 4'd11}) ? a : 4'd15;
  endfunction

  function automatic logic [63:0] modelRead(input logic [3:0] addr);
    return (addr == 4'd15) ? 64'd0 : m_regs[addr];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_stat   = 3'd1;
    m_halted = 1'b0;
    m_cnt    = 32'd0;
  endtask

  // Applies the rules of one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [3:0] de;
    logic [3:0] dm;
    if (!m_halted && commit) begin
      m_cnt = m_cnt + 32'd1;
      if (icode == 4'd0 || stat_in != 3'd1) begin
        m_halted = 1'b1;
        m_stat   = (icode == 4'd0) ? 3'd2 : stat_in;
      end else begin
        de = modelDstE(icode, rB, cnd);
        dm = modelDstM(icode, rA);
        if (de != 4'd15) m_regs[de] = valE;
        if (dm != 4'd15) m_regs[dm] = valM;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".rd_a"}, rd_a_data, modelRead(rd_a_addr));
    checkValue({tag, ".rd_b"}, rd_b_data, modelRead(rd_b_addr));
    checkValue({tag, ".stat"}, 64'(stat_out), 64'(m_stat));
    checkValue({tag, ".halted"}, 64'(halted), 64'(m_halted));
    checkValue({tag, ".cnt"}, 64'(commit_cnt), 64'(m_cnt));
  endtask

  // Drives one instruction, then checks pre-edge state at the falling edge.
  task automatic applyStimulus(input string tag, input logic c, input logic [3:0] ic,
                               input logic [3:0] a, input logic [3:0] b, input logic cn,
                               input logic [63:0] ve, input logic [63:0] vm, input logic [2:0] st,
                               input logic [3:0] ra_addr, input logic [3:0] rb_addr);
    commit    = c;
    icode     = ic;
    rA        = a;
    rB        = b;
    cnd       = cn;
    valE      = ve;
    valM      = vm;
    stat_in   = st;
    rd_a_addr = ra_addr;
    rd_b_addr = rb_addr;
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Asserts reset away from the clock edge and holds it across one rising edge.
  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_a_addr = 4'(i);
      rd_b_addr = 4'(15 - i);
      #1;
      checkValue("reset_reg", rd_a_data, 64'd0);
    end
    checkValue("reset_stat", 64'(stat_out), 64'd1);
    checkValue("reset_halted", 64'(halted), 64'd0);
    checkValue("reset_cnt", 64'(commit_cnt), 64'd0);
    @(negedge clk);
    commit = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    commit = 0; icode = 0; rA = 0; rB = 0; cnd = 0;
    valE = 0; valM = 0; stat_in = 3'd1; rd_a_addr = 0; rd_b_addr = 0;
    rst_n = 1'b0;
    #2;
    doReset();

    applyStimulus("irmovq", 1, 4'd3, 4'd15, 4'd2, 0, 64'h1234, 64'h0, 3'd1, 4'd2, 4'd15);
    clockEdge();
    applyStimulus("irmovq_rd", 0, 4'd1, 4'd0, 4'd0, 0, 64'h0, 64'h0, 3'd1, 4'd2, 4'd3);
    checkValue("irmovq_r2", rd_a_data, 64'h1234);
    checkValue("irmovq_cnt", 64'(commit_cnt), 64'd1);
    clockEdge();

    applyStimulus("cmov_f", 1, 4'd2, 4'd0, 4'd3, 0, 64'd5, 64'h0, 3'd1, 4'd3, 4'd0);
    clockEdge();
    applyStimulus("cmov_t", 1, 4'd2, 4'd0, 4'd3, 1, 64'd5, 64'h0, 3'd1, 4'd3, 4'd0);
    checkValue("cmov_cnd0", rd_a_data, 64'd0);
    clockEdge();

    applyStimulus("popq_rsp", 1, 4'd11, 4'd4, 4'd15, 0, 64'h100, 64'hBEEF, 3'd1, 4'd3, 4'd4);
    checkValue("cmov_cnd1", rd_a_data, 64'd5);
    clockEdge();

    applyStimulus("mrmovq", 1, 4'd5, 4'd7, 4'd15, 0, 64'h0, 64'hAA, 3'd1, 4'd4, 4'd7);
    checkValue("popq_rsp_r4", rd_a_data, 64'hBEEF);
    checkValue("mrmovq_old", rd_b_data, 64'd0);
    clockEdge();
    applyStimulus("mrmovq_rd", 0, 4'd1, 4'd0, 4'd0, 0, 64'h0, 64'h0, 3'd1, 4'd7, 4'd15);
    checkValue("mrmovq_new", rd_a_data, 64'hAA);
    clockEdge();

    applyStimulus("adr", 1, 4'd5, 4'd1, 4'd15, 0, 64'h0, 64'h77, 3'd3, 4'd1, 4'd15);
    clockEdge();
    applyStimulus("adr_after", 1, 4'd3, 4'd15, 4'd1, 0, 64'h99, 64'h0, 3'd1, 4'd1, 4'd15);
    checkValue("adr_stat", 64'(stat_out), 64'd3);
    checkValue("adr_halted", 64'(halted), 64'd1);
    checkValue("adr_nowrite", rd_a_data, 64'd0);
    clockEdge();
    applyStimulus("halt_frozen", 0, 4'd1, 4'd0, 4'd0, 0, 64'h0, 64'h0, 3'd1, 4'd1, 4'd15);
    checkValue("halt_ignore_r1", rd_a_data, 64'd0);
    checkValue("halt_ignore_cnt", 64'(commit_cnt), 64'd6);
    clockEdge();

    doReset();
    applyStimulus("ihalt", 1, 4'd0, 4'd0, 4'd0, 0, 64'h0, 64'h0, 3'd1, 4'd0, 4'd0);
    clockEdge();
    applyStimulus("ihalt_after", 1, 4'd3, 4'd15, 4'd0, 0, 64'h55, 64'h0, 3'd1, 4'd0, 4'd15);
    checkValue("ihalt_stat", 64'(stat_out), 64'd2);
    checkValue("ihalt_halted", 64'(halted), 64'd1);
    doReset();

    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic;
      logic [2:0] st;
      ic = ($urandom_range(0, 29) == 0) ? 4'd0 : 4'($urandom_range(1, 13));
      st = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), ic,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom}, st,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      clockEdge();
      if (m_halted && $urandom_range(0, 3) == 0) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
